// File: rtl/bsg_regbank_tx.sv
// bsg_regbank_tx: bus-programmed register bank that streams DATA_0..DATA_(LEN-1)
// to the encoder over a valid/ready handshake, with done/abort status and IRQ.
module bsg_regbank_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 'h10,
   parameter int NUM_DATA   = 2
) (
   input  logic                  G_CLK_TX,
   input  logic                  rst,
   input  logic                  BUS_SEL,
   input  logic                  BUS_WRITE,
   input  logic [ADDR_WIDTH-1:0] ADDR_IN,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  DATA_OUT_VALID,
   output logic [DATA_WIDTH-1:0] TX_DATA,
   output logic                  TX_VALID,
   input  logic                  TX_READY,
   output logic                  TX_LAST,
   output logic                  BUSY,
   output logic                  IRQ
);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

   state_t                  state_reg, state_next;
   logic [DATA_WIDTH-1:0]   idx_reg, idx_next;
   logic [DATA_WIDTH-1:0]   len_reg;
   logic [DATA_WIDTH-1:0]   data_reg [NUM_DATA];
   logic                    irq_en_reg, loop_reg;
   logic                    done_reg, aborted_reg;
   logic [DATA_WIDTH-1:0]   data_out_reg;
   logic                    data_out_valid_reg;

   logic [ADDR_WIDTH-1:0]   addr_off;
   logic                    in_window, wr_en, rd_en;
   logic                    sel_ctrl, sel_stat, sel_len;
   logic [NUM_DATA-1:0]     sel_data;
   logic                    start_cmd, abort_cmd, stat_rd;
   logic                    len_ok, last_word, sending;
   logic                    done_set, abort_set;
   logic [DATA_WIDTH-1:0]   rd_data, tx_word;

   // Address decode: the window covers CONTROL, STATUS, LEN and every DATA_i.
   assign addr_off  = ADDR_IN - BASE;
   assign in_window = (ADDR_IN >= BASE) && (addr_off <= ADDR_WIDTH'(2 + NUM_DATA));
   assign wr_en     = BUS_SEL & BUS_WRITE & in_window;
   assign rd_en     = BUS_SEL & ~BUS_WRITE & in_window;
   assign sel_ctrl  = (addr_off == ADDR_WIDTH'(0));
   assign sel_stat  = (addr_off == ADDR_WIDTH'(1));
   assign sel_len   = (addr_off == ADDR_WIDTH'(2));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DATA; gi++) begin : g_sel
         assign sel_data[gi] = (addr_off == ADDR_WIDTH'(3 + gi));
      end
   endgenerate

   // ABORT in the same write masks START entirely.
   assign start_cmd = wr_en & sel_ctrl & DATA_IN[0] & ~DATA_IN[3];
   assign abort_cmd = wr_en & sel_ctrl & DATA_IN[3];
   assign stat_rd   = rd_en & sel_stat;
   assign sending   = (state_reg == ST_SEND);
   assign len_ok    = (len_reg != '0) && (len_reg <= DATA_WIDTH'(NUM_DATA));
   assign last_word = (idx_reg == len_reg - DATA_WIDTH'(1));

   // Next-state logic for the transfer sequencer and the done/abort set events.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      done_set   = 1'b0;
      abort_set  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start_cmd) begin
               if (len_ok) begin
                  state_next = ST_SEND;
                  idx_next   = '0;
               end else begin
                  done_set = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (TX_READY) begin
               if (!last_word) begin
                  idx_next = idx_reg + DATA_WIDTH'(1);
               end else begin
                  done_set = 1'b1;
                  idx_next = '0;
                  if (!loop_reg) state_next = ST_IDLE;
               end
            end
            // Abort overrides everything and leaves DONE untouched.
            if (abort_cmd) begin
               state_next = ST_IDLE;
               idx_next   = '0;
               done_set   = 1'b0;
               abort_set  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Sequencer state and word index.
   always_ff @(posedge G_CLK_TX or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   // Programmable registers; LEN and DATA are frozen while a transfer runs.
   always_ff @(posedge G_CLK_TX or negedge rst) begin
      if (!rst) begin
         irq_en_reg <= 1'b0;
         loop_reg   <= 1'b0;
         len_reg    <= '0;
         for (int i = 0; i < NUM_DATA; i++) data_reg[i] <= '0;
      end else begin
         if (wr_en && sel_ctrl) begin
            irq_en_reg <= DATA_IN[1];
            loop_reg   <= DATA_IN[2];
         end
         if (wr_en && sel_len && !sending) len_reg <= DATA_IN;
         for (int i = 0; i < NUM_DATA; i++) begin
            if (wr_en && sel_data[i] && !sending) data_reg[i] <= DATA_IN;
         end
      end
   end

   // Sticky flags: a STATUS read clears them, a same-cycle set event wins.
   always_ff @(posedge G_CLK_TX or negedge rst) begin
      if (!rst) begin
         done_reg    <= 1'b0;
         aborted_reg <= 1'b0;
      end else begin
         done_reg    <= done_set  | (done_reg    & ~stat_rd);
         aborted_reg <= abort_set | (aborted_reg & ~stat_rd);
      end
   end

   // Read data mux; unused upper bits stay zero.
   always_comb begin
      rd_data = '0;
      if (sel_ctrl) begin
         rd_data[1] = irq_en_reg;
         rd_data[2] = loop_reg;
      end
      if (sel_stat) rd_data[3:0] = {sending, aborted_reg, done_reg, sending};
      if (sel_len)  rd_data = len_reg;
      for (int i = 0; i < NUM_DATA; i++) begin
         if (sel_data[i]) rd_data = data_reg[i];
      end
   end

   // Registered read port: DATA_OUT holds between in-window reads.
   always_ff @(posedge G_CLK_TX or negedge rst) begin
      if (!rst) begin
         data_out_reg       <= '0;
         data_out_valid_reg <= 1'b0;
      end else begin
         data_out_valid_reg <= rd_en;
         if (rd_en) data_out_reg <= rd_data;
      end
   end

   // Word selected by the current index.
   always_comb begin
      tx_word = '0;
      for (int i = 0; i < NUM_DATA; i++) begin
         if (idx_reg == DATA_WIDTH'(i)) tx_word = data_reg[i];
      end
   end

   assign TX_DATA        = sending ? tx_word : '0;
   assign TX_VALID       = sending;
   assign TX_LAST        = sending & last_word;
   assign BUSY           = sending;
   assign IRQ            = done_reg & irq_en_reg;
   assign DATA_OUT       = data_out_reg;
   assign DATA_OUT_VALID = data_out_valid_reg;

endmodule
